muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencer for the HI/LO arithmetic unit of the bus-architecture CPU. It accepts MUL/DIV commands from the control unit and drives the existing combinational Booth multiplier through registered operands with a configurable settle window. It also runs an internal signed restoring divider, and returns the 2·BITS-bit result on HI/LO with a busy/done handshake.

## Interface
- BITS, 32, operand width; must be even and ≥4
- MUL_CYCLES, 2, clock edges allowed for multiplier settle (multicycle path); must be ≥1
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only when busy=0
- op  in  1  0 = MUL (signed), 1 = DIV (signed)
- a  in  BITS  multiplicand / dividend
- b  in  BITS  multiplier / divisor
- mul_a  out  BITS  registered multiplicand to multiplier
- mul_b  out  BITS  registered multiplier to multiplier
- mul_p  in  2·BITS  product from multiplier
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  BITS  MUL: product[2·BITS-1:BITS]; DIV: remainder
- lo  out  BITS  MUL: product[BITS-1:0]; DIV: quotient
- div_by_zero  out  1  last completed op was DIV with b=0

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX. All outputs are registered.
- Reset (rst=1 at an edge): state=IDLE; busy, done, div_by_zero=0; hi, lo, mul_a, mul_b, all counters and divider registers=0. rst overrides start. Reset mid-operation aborts that operation with no done pulse.
- IDLE, start=1, op=0:
  - mul_a←a, mul_b←b; cnt←MUL_CYCLES-1; busy←1; → MUL_WAIT.
- MUL_WAIT:
  - cnt≠0: cnt←cnt-1.
  - cnt=0: {hi,lo}←mul_p; div_by_zero←0; done←1; busy←0; → IDLE.
- IDLE, start=1, op=1, b=0:
  - hi←a; lo←all ones; div_by_zero←1; done←1; stay IDLE; busy stays 0.
- IDLE, start=1, op=1, b≠0:
  - Latch |a|, |b|, sa=a[BITS-1], sq=a[BITS-1]^b[BITS-1].
  - Clear partial remainder; cnt←BITS-1; busy←1; → DIV_RUN.
- DIV_RUN, one restoring step per edge, MSB-first:
  - rem←{rem, next dividend bit}.
  - If rem≥|b|: rem←rem−|b| and quotient bit=1; else quotient bit=0.
  - After BITS steps → DIV_FIX.
- DIV_FIX:
  - lo←sq ? −q : q; hi←sa ? −rem : rem.
  - div_by_zero←0; done←1; busy←0; → IDLE.
- Arithmetic: the quotient truncates toward zero and the remainder carries the sign of the dividend.
  - Overflow case (−2^(BITS−1))/(−1): lo=0x80000000 (wraps), hi=0. No flag.
- done is high for exactly one cycle, then clears. hi, lo and div_by_zero hold until the next completion or reset.
- start while busy=1 is ignored; a, b and op are not latched.
- start during the done cycle is accepted, since state is already IDLE.
- mul_a and mul_b hold their last values outside a MUL.

## Timing
- Let E0 be the edge that samples an accepted start.
- MUL:
  - Result captured at edge E0+MUL_CYCLES.
  - busy=1 from E0 until that edge.
  - done=1 in the cycle following E0+MUL_CYCLES.
- DIV, b≠0:
  - BITS steps at E1..E_BITS; sign fix at E_(BITS+1).
  - done after E_(BITS+1): 33 edges for BITS=32.
- DIV, b=0: result and done=1 after E0 (latency 1); busy never asserts.
- Throughput: a new command may be accepted at the edge that ends the done cycle.
- mul_p must settle within MUL_CYCLES clock periods of mul_a/mul_b changing.

## Test plan
- MUL, MUL_CYCLES=2:
  - a=7, b=−3 → {hi,lo}=0xFFFFFFFF_FFFFFFEB.
  - busy high for 2 cycles; done pulses in the cycle after E2; div_by_zero=0.
- DIV a=100, b=7 → lo=14, hi=2; busy for 33 cycles; single done pulse after E33.
- DIV a=−100, b=7 → lo=0xFFFFFFF2 (−14), hi=0xFFFFFFFE (−2). DIV a=100, b=−7 → lo=−14, hi=2.
- DIV a=5, b=0 → after E0: lo=0xFFFFFFFF, hi=5, div_by_zero=1, done=1, busy stays 0.
- Command handling:
  - Start a MUL while a DIV is busy → ignored; DIV result unaffected.
  - Issue a MUL in the done cycle of the DIV → MUL accepted; its result follows 2 edges later.
- Reset mid-DIV (rst at E10):
  - Next cycle busy=0, hi=lo=0, no done pulse.
  - A following MUL 0x80000000×2 → {hi,lo}=0xFFFFFFFF_00000000.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO sequencer: registered operands for an external multiplier, internal signed restoring divider
module muldiv_ctrl #(
  parameter int BITS       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  output logic [BITS-1:0]   mul_a,
  output logic [BITS-1:0]   mul_b,
  input  logic [2*BITS-1:0] mul_p,
  output logic              busy,
  output logic              done,
  output logic [BITS-1:0]   hi,
  output logic [BITS-1:0]   lo,
  output logic              div_by_zero
);

  localparam int MAXC = (BITS > MUL_CYCLES) ? BITS : MUL_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            busy_n, done_n, dbz_n;
  logic [BITS-1:0] hi_n, lo_n, mul_a_n, mul_b_n;
  // dvd starts as |a| and shifts quotient bits in from the LSB as dividend bits leave the MSB
  logic [BITS-1:0] dvd, dvd_n, dvs, dvs_n, rem, rem_n;
  logic            sa, sa_n, sq, sq_n;
  logic [BITS:0]   trial;
  logic            qbit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      sa          <= 1'b0;
      sq          <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
      hi          <= hi_n;
      lo          <= lo_n;
      mul_a       <= mul_a_n;
      mul_b       <= mul_b_n;
      dvd         <= dvd_n;
      dvs         <= dvs_n;
      rem         <= rem_n;
      sa          <= sa_n;
      sq          <= sq_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    dbz_n   = div_by_zero;
    hi_n    = hi;
    lo_n    = lo;
    mul_a_n = mul_a;
    mul_b_n = mul_b;
    dvd_n   = dvd;
    dvs_n   = dvs;
    rem_n   = rem;
    sa_n    = sa;
    sq_n    = sq;
    trial   = {rem, dvd[BITS-1]};
    qbit    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op) begin
            mul_a_n = a;
            mul_b_n = b;
            cnt_n   = CW'(MUL_CYCLES - 1);
            busy_n  = 1'b1;
            state_n = MUL_WAIT;
          end else if (b == '0) begin
            hi_n   = a;
            lo_n   = '1;
            dbz_n  = 1'b1;
            done_n = 1'b1;
          end else begin
            dvd_n   = a[BITS-1] ? -a : a;
            dvs_n   = b[BITS-1] ? -b : b;
            sa_n    = a[BITS-1];
            sq_n    = a[BITS-1] ^ b[BITS-1];
            rem_n   = '0;
            cnt_n   = CW'(BITS - 1);
            busy_n  = 1'b1;
            state_n = DIV_RUN;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          hi_n    = mul_p[2*BITS-1:BITS];
          lo_n    = mul_p[BITS-1:0];
          dbz_n   = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      DIV_RUN: begin
        // remainder stays below |b| <= 2^(BITS-1), so the difference always fits BITS bits
        if (trial >= {1'b0, dvs}) begin
          rem_n = trial[BITS-1:0] - dvs;
          qbit  = 1'b1;
        end else begin
          rem_n = trial[BITS-1:0];
        end
        dvd_n = {dvd[BITS-2:0], qbit};
        if (cnt == '0) state_n = DIV_FIX;
        else           cnt_n   = cnt - 1'b1;
      end
      DIV_FIX: begin
        lo_n    = sq ? -dvd : dvd;
        hi_n    = sa ? -rem : rem;
        dbz_n   = 1'b0;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
